// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_MARK,
        ST_LOAD,
        ST_FAIL
    } state_t;

    // Width of a counter that must hold values 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_loader_if.sv
// Ready/valid word stream from the on-chip bitstream buffer into the loader.
interface ccff_loader_if #(
    parameter int WORD_W = 4
);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ccff_loader_ser.sv
// Word-to-bit serializer: one holding register in front of a WORD_W-bit shift register.
module ccff_loader_ser #(
    parameter int WORD_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_en,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    input  logic              bit_ready,
    output logic              bit_valid,
    output logic              bit_data
);

    localparam int CW = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] sreg;
    logic [WORD_W-1:0] hold;
    logic [CW-1:0]     scnt;
    logic              hold_vld;
    logic              accept;

    assign in_ready = in_en && !hold_vld;
    assign accept   = in_valid && in_ready;

    // A word arriving into a fully empty serializer presents its bit 0 the same cycle.
    always_comb begin
        bit_valid = 1'b0;
        bit_data  = 1'b0;
        if (scnt != '0) begin
            bit_valid = 1'b1;
            bit_data  = sreg[0];
        end else if (hold_vld) begin
            bit_valid = 1'b1;
            bit_data  = hold[0];
        end else if (accept) begin
            bit_valid = 1'b1;
            bit_data  = in_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg     <= '0;
            hold     <= '0;
            scnt     <= '0;
            hold_vld <= 1'b0;
        end else if (scnt != '0) begin
            if (bit_ready) begin
                sreg <= sreg >> 1;
                scnt <= scnt - 1'b1;
            end
            if (accept) begin
                hold     <= in_data;
                hold_vld <= 1'b1;
            end
        end else if (hold_vld) begin
            if (bit_ready) begin
                sreg     <= hold >> 1;
                scnt     <= CW'(WORD_W - 1);
                hold_vld <= 1'b0;
            end
        end else if (accept) begin
            if (bit_ready) begin
                sreg <= in_data >> 1;
                scnt <= CW'(WORD_W - 1);
            end else begin
                hold     <= in_data;
                hold_vld <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Configuration-chain loader: flush, marker length probe, then serial payload load.
//   state    | meaning
//   IDLE     | waiting for start
//   FLUSH    | shifting CHAIN_LEN zeros into the chain
//   MARK     | marker shifted in, tail must show it exactly CHAIN_LEN shifts later
//   LOAD     | streaming payload bits from the serializer
//   FAIL     | chain length mismatch, flag error and return to IDLE
module ccff_loader
    import ccff_loader_pkg::*;
#(
    parameter int  CHAIN_LEN = 10,
    parameter int  WORD_W    = 4,
    localparam int BW        = cnt_w(CHAIN_LEN)
) (
    input  logic          prog_clk,
    input  logic          prog_reset,
    input  logic          start,
    ccff_loader_if.slave  word,
    output logic          ccff_head,
    output logic          ccff_clk_en,
    input  logic          ccff_tail,
    output logic          busy,
    output logic          done,
    output logic          err_len,
    output logic [BW-1:0] bits_loaded
);

    localparam int            AW  = $clog2(CHAIN_LEN + WORD_W + 1);
    localparam logic [BW-1:0] LEN = BW'(CHAIN_LEN);

    state_t        state;
    logic [BW-1:0] cnt;
    logic [AW-1:0] acc_bits;
    logic          ser_in_ready;
    logic          ser_valid;
    logic          ser_bit;
    logic          take;
    logic          in_en;

    assign take       = (state == ST_LOAD) && (bits_loaded != LEN);
    assign in_en      = (state == ST_LOAD) && (acc_bits < AW'(CHAIN_LEN));
    assign word.ready = ser_in_ready;

    ccff_loader_ser #(.WORD_W(WORD_W)) u_ser (
        .clk       (prog_clk),
        .rst       (prog_reset),
        .clear     (state != ST_LOAD),
        .in_en     (in_en),
        .in_valid  (word.valid),
        .in_data   (word.data),
        .in_ready  (ser_in_ready),
        .bit_ready (take),
        .bit_valid (ser_valid),
        .bit_data  (ser_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            acc_bits    <= '0;
            ccff_head   <= 1'b0;
            ccff_clk_en <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_len     <= 1'b0;
            bits_loaded <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_FLUSH;
                        err_len     <= 1'b0;
                        bits_loaded <= '0;
                        acc_bits    <= '0;
                        busy        <= 1'b1;
                        ccff_head   <= 1'b0;
                        ccff_clk_en <= 1'b1;
                        cnt         <= LEN - 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (cnt == '0) begin
                        state     <= ST_MARK;
                        ccff_head <= 1'b1;
                        cnt       <= LEN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_MARK: begin
                    // cnt == LEN is the marker cycle itself; the tail is not judged there.
                    ccff_head <= 1'b0;
                    if (cnt == '0) begin
                        ccff_clk_en <= 1'b0;
                        if (ccff_tail) begin
                            state <= ST_LOAD;
                        end else begin
                            state   <= ST_FAIL;
                            err_len <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end else if (cnt != LEN && ccff_tail) begin
                        state       <= ST_FAIL;
                        err_len     <= 1'b1;
                        busy        <= 1'b0;
                        ccff_clk_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (bits_loaded == LEN) begin
                        state       <= ST_IDLE;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        ccff_clk_en <= 1'b0;
                    end else if (ser_valid) begin
                        ccff_head   <= ser_bit;
                        ccff_clk_en <= 1'b1;
                        bits_loaded <= bits_loaded + 1'b1;
                    end else begin
                        ccff_clk_en <= 1'b0;
                    end
                    if (word.valid && ser_in_ready) begin
                        acc_bits <= acc_bits + AW'(WORD_W);
                    end
                end
                ST_FAIL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with a behavioural configuration-chain model of variable length.
module tb_ccff_loader;

    localparam int L  = 10;
    localparam int W  = 4;
    localparam int BW = $clog2(L + 1);

    logic          prog_clk   = 1'b0;
    logic          prog_reset = 1'b1;
    logic          start      = 1'b0;
    logic          ccff_head;
    logic          ccff_clk_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          err_len;
    logic [BW-1:0] bits_loaded;

    ccff_loader_if #(.WORD_W(W)) word_bus ();

    ccff_loader #(.CHAIN_LEN(L), .WORD_W(W)) dut (
        .prog_clk    (prog_clk),
        .prog_reset  (prog_reset),
        .start       (start),
        .word        (word_bus),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
        .busy        (busy),
        .done        (done),
        .err_len     (err_len),
        .bits_loaded (bits_loaded)
    );

    always #5 prog_clk = ~prog_clk;

    // chain[0] is the flop nearest ccff_head; chain[chain_n-1] drives ccff_tail.
    logic [15:0] chain;
    logic        chain_load = 1'b0;
    logic        stuck0     = 1'b0;
    int          chain_n    = L;

    always @(posedge prog_clk) begin
        if (chain_load) chain <= '1;
        else if (ccff_clk_en) chain <= {chain[14:0], ccff_head};
    end

    assign ccff_tail = stuck0 ? 1'b0 : chain[4'(chain_n - 1)];

    logic [W-1:0] words [3] = '{4'hA, 4'h5, 4'h3};
    int           offer_at [3] = '{0, 0, 0};

    int   errors = 0;
    int   checks = 0;
    int   cyc;
    int   wq_idx;
    int   done_cyc, err_cyc, busy_cyc, mark_cyc;
    int   stall_cnt;
    int   xstart_a = -1;
    int   xstart_b = -1;
    logic ready_seen, head_moved, head_prev;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; observe outputs of the new cycle, then drive its inputs.
    task automatic cycle();
        @(negedge prog_clk);
        cyc++;
        if (done && done_cyc < 0) done_cyc = cyc;
        if (err_len && err_cyc < 0) err_cyc = cyc;
        if (busy && busy_cyc < 0) busy_cyc = cyc;
        if (ccff_clk_en && ccff_head && mark_cyc < 0) mark_cyc = cyc;
        if (word_bus.ready) ready_seen = 1'b1;
        if (busy && !ccff_clk_en) begin
            stall_cnt++;
            if (ccff_head !== head_prev) head_moved = 1'b1;
        end
        head_prev  = ccff_head;
        start      = (cyc == xstart_a) || (cyc == xstart_b);
        chain_load = 1'b0;
        if (wq_idx < 3 && cyc >= offer_at[wq_idx]) begin
            word_bus.valid = 1'b1;
            word_bus.data  = words[wq_idx];
            if (word_bus.ready) wq_idx++;
        end else begin
            word_bus.valid = 1'b0;
            word_bus.data  = '0;
        end
    endtask

    // Cycle 0 of a sequence: reinitialise the chain to ones and pulse start.
    task automatic begin_seq(input int n_chain, input logic stuck, input int off2);
        @(negedge prog_clk);
        cyc        = 0;
        wq_idx     = 0;
        done_cyc   = -1;
        err_cyc    = -1;
        busy_cyc   = -1;
        mark_cyc   = -1;
        stall_cnt  = 0;
        ready_seen = 1'b0;
        head_moved = 1'b0;
        head_prev  = ccff_head;
        chain_n    = n_chain;
        stuck0     = stuck;
        offer_at[2] = off2;
        chain_load = 1'b1;
        start      = 1'b1;
        word_bus.valid = 1'b0;
        word_bus.data  = '0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " err_len"}, 32'(err_len), 32'd0);
        check({tag, " ccff_head"}, 32'(ccff_head), 32'd0);
        check({tag, " ccff_clk_en"}, 32'(ccff_clk_en), 32'd0);
        check({tag, " word_ready"}, 32'(word_bus.ready), 32'd0);
        check({tag, " bits_loaded"}, 32'(bits_loaded), 32'd0);
    endtask

    initial begin
        word_bus.valid = 1'b0;
        word_bus.data  = '0;

        repeat (2) @(negedge prog_clk);
        check_idle_outputs("reset");
        prog_reset = 1'b0;

        // Nominal load: words 0xA, 0x5, 0x3 back-to-back into a 10-flop chain.
        begin_seq(10, 1'b0, 0);
        repeat (45) cycle();
        check("nominal busy_first", busy_cyc, 1);
        check("nominal marker_cycle", mark_cyc, 11);
        check("nominal done_cycle", done_cyc, 33);
        check("nominal chain", 32'(chain[9:0]), 32'b0101101011);
        check("nominal err_len", 32'(err_len), 32'd0);
        check("nominal bits_loaded", 32'(bits_loaded), 32'd10);
        check("nominal stall_cycles", stall_cnt, 1);
        check("nominal busy_after", 32'(busy), 32'd0);

        // 9-flop chain: marker reaches the tail at index 9.
        begin_seq(9, 1'b0, 0);
        repeat (30) cycle();
        check("short err_cycle", err_cyc, 21);
        check("short err_len", 32'(err_len), 32'd1);
        check("short done_seen", done_cyc, -1);
        check("short word_ready_seen", 32'(ready_seen), 32'd0);
        check("short busy", 32'(busy), 32'd0);

        // 11-flop chain: tail still 0 at index 10.
        begin_seq(11, 1'b0, 0);
        repeat (30) cycle();
        check("long err_cycle", err_cyc, 22);
        check("long err_len", 32'(err_len), 32'd1);
        check("long done_seen", done_cyc, -1);

        // Tail stuck at 0.
        begin_seq(10, 1'b1, 0);
        repeat (30) cycle();
        check("stuck err_cycle", err_cyc, 22);
        check("stuck err_len", 32'(err_len), 32'd1);
        check("stuck word_ready_seen", 32'(ready_seen), 32'd0);

        // Last word withheld until cycle 35: loader starves for 5 cycles.
        begin_seq(10, 1'b0, 35);
        repeat (45) cycle();
        check("stall err_cleared", err_cyc, -1);
        check("stall done_cycle", done_cyc, 38);
        check("stall stall_cycles", stall_cnt, 6);
        check("stall head_moved", 32'(head_moved), 32'd0);
        check("stall chain", 32'(chain[9:0]), 32'b0101101011);
        check("stall bits_loaded", 32'(bits_loaded), 32'd10);

        // Reset after 4 payload bits.
        begin_seq(10, 1'b0, 0);
        for (int i = 0; i < 40 && bits_loaded != BW'(4); i++) cycle();
        check("midreset bits_before", 32'(bits_loaded), 32'd4);
        check("midreset head_before", 32'(ccff_head), 32'd1);
        prog_reset = 1'b1;
        @(negedge prog_clk);
        check_idle_outputs("midreset");
        prog_reset = 1'b0;

        // Fresh sequence with extra start pulses in FLUSH and LOAD.
        xstart_a = 5;
        xstart_b = 25;
        begin_seq(10, 1'b0, 0);
        repeat (45) cycle();
        xstart_a = -1;
        xstart_b = -1;
        check("restart busy_first", busy_cyc, 1);
        check("restart marker_cycle", mark_cyc, 11);
        check("restart done_cycle", done_cyc, 33);
        check("restart chain", 32'(chain[9:0]), 32'b0101101011);
        check("restart err_len", 32'(err_len), 32'd0);
        check("restart bits_loaded", 32'(bits_loaded), 32'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
